// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control path: FSM states,
// instruction field codes and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } statetype_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation and flag-write decode for data-processing
// instructions; flags an unsupported cmd so the controller can report it.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       bad_cmd
);

  // The immediate bit only steers the FSM, not the ALU operation.
  logic unused_imm;
  assign unused_imm = Funct[5];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    bad_cmd    = 1'b0;
    if (ALUOp) begin
      case (Funct[4:1])
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          FlagW      = {Funct[0], Funct[0]};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          FlagW      = {Funct[0], Funct[0]};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          FlagW      = {Funct[0], 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          FlagW      = {Funct[0], 1'b0};
        end
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          FlagW      = {Funct[0], Funct[0]};
          NoWrite    = 1'b1;
        end
        default: bad_cmd = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multicycle datapath: steps each instruction
// through its states and decodes mux selects and write requests from state.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic       instr_done,
  output logic       illegal
);

  statetype_t state_q, state_d;
  logic       alu_op;
  logic       branch;
  logic       illegal_op;
  logic       bad_cmd;

  // Next-state and per-state output decode.
  always_comb begin
    state_d    = state_q;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    RegW       = 1'b0;
    MemW       = 1'b0;
    alu_op     = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegW       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        ALUSrcB = SRCB_REG;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_op  = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegW       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ALUOp is only high in EXECR/EXECI, which confines FlagW and NoWrite there.
  alu_decoder u_alu_decoder (
    .ALUOp     (alu_op),
    .Funct     (Funct),
    .ALUControl(ALUControl),
    .FlagW     (FlagW),
    .NoWrite   (NoWrite),
    .bad_cmd   (bad_cmd)
  );

  assign PCS     = ((Rd == PC_REG) & RegW) | branch;
  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == OP_MEM), (Op == OP_BR)};
  assign illegal = illegal_op | (alu_op & bad_cmd);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-computed
// per-state output vectors.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       mem_ready;
  logic       IRWrite, NextPC, AdrSrc, RegW, MemW, PCS, NoWrite, instr_done, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;

  int tests  = 0;
  int failed = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegW(RegW), .MemW(MemW), .PCS(PCS),
    .NoWrite(NoWrite), .FlagW(FlagW), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Vector order: IRWrite NextPC AdrSrc ALUSrcA ALUSrcB ResultSrc ALUControl
  //               RegW MemW PCS NoWrite FlagW instr_done illegal
  task automatic expect_outs(input string tag, input logic irw, input logic npc,
                             input logic adr, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] rs, input logic [1:0] alc, input logic rw,
                             input logic mw, input logic pcs, input logic nw,
                             input logic [1:0] fw, input logic done, input logic ill);
    check(tag,
          32'({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               RegW, MemW, PCS, NoWrite, FlagW, instr_done, illegal}),
          32'({irw, npc, adr, sa, sb, rs, alc, rw, mw, pcs, nw, fw, done, ill}));
  endtask

  task automatic expect_fetch(input string tag, input logic mr);
    expect_outs(tag, mr, mr, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic expect_decode(input string tag);
    expect_outs(tag, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Full data-processing instruction with no wait states: FETCH, DECODE, EXEC, ALUWB.
  task automatic dp_instr(input string tag, input logic [5:0] f, input logic [3:0] rd,
                          input logic [1:0] sb, input logic [1:0] alc, input logic [1:0] fw,
                          input logic nw, input logic ill, input logic pcs);
    Op = 2'b00; Funct = f; Rd = rd; mem_ready = 1'b1;
    #1;
    expect_fetch({tag, "_fetch"}, 1'b1);
    tick();
    expect_decode({tag, "_decode"});
    tick();
    expect_outs({tag, "_exec"}, 1'b0, 1'b0, 1'b0, 2'b00, sb, 2'b00, alc,
                1'b0, 1'b0, 1'b0, nw, fw, 1'b0, ill);
    tick();
    expect_outs({tag, "_aluwb"}, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00,
                1'b1, 1'b0, pcs, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; mem_ready = 1'b0;
    #1;
    expect_fetch("rst_fetch_nr", 1'b0);
    mem_ready = 1'b1;
    #1;
    expect_fetch("rst_fetch_rdy", 1'b1);
    tick();
    expect_fetch("rst_hold", 1'b1);
    reset = 1'b0;

    // ADD S=1 Rd=3, CMP imm, ORR S=1, AND imm S=1, SUB S=1 to PC, unsupported cmd
    dp_instr("add_s",  6'b001001, 4'd3,  2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    dp_instr("cmp_i",  6'b110101, 4'd0,  2'b01, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
    dp_instr("orr_s",  6'b011001, 4'd4,  2'b00, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    dp_instr("and_is", 6'b100001, 4'd5,  2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
    dp_instr("sub_pc", 6'b000101, 4'd15, 2'b00, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1);
    dp_instr("badcmd", 6'b000110, 4'd1,  2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // Reset asserted asynchronously while in EXECR aborts the instruction.
    Op = 2'b00; Funct = 6'b001000; Rd = 4'd2; mem_ready = 1'b1;
    #1;
    expect_fetch("abort_fetch", 1'b1);
    tick();
    expect_decode("abort_decode");
    tick();
    expect_outs("abort_execr", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    expect_fetch("abort_async", 1'b1);
    tick();
    reset = 1'b0;
    #1;
    expect_fetch("abort_release", 1'b1);
    tick();
    expect_decode("abort_refetch_decode");
    Op = 2'b10;
    tick();
    expect_outs("abort_branch", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00,
                1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();

    // LDR to PC with two wait cycles in MEMRD: 7 cycles total.
    Op = 2'b01; Funct = 6'b000001; Rd = 4'd15; mem_ready = 1'b1;
    #1;
    expect_fetch("ldr_fetch", 1'b1);
    check("ldr_immsrc", 32'(ImmSrc), 32'd1);
    check("ldr_regsrc", 32'(RegSrc), 32'd2);
    tick();
    expect_decode("ldr_decode");
    tick();
    expect_outs("ldr_memadr", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_ready = 1'b1;
      #1;
      expect_outs($sformatf("ldr_memrd%0d", i), 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00,
                  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    tick();
    expect_outs("ldr_memwb", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00,
                1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    expect_fetch("ldr_back_fetch", 1'b1);

    // STR with one FETCH wait and one MEMWR wait.
    Op = 2'b01; Funct = 6'b000000; Rd = 4'd2; mem_ready = 1'b0;
    #1;
    expect_fetch("str_fetch_wait", 1'b0);
    tick();
    mem_ready = 1'b1;
    #1;
    expect_fetch("str_fetch_rdy", 1'b1);
    tick();
    expect_decode("str_decode");
    tick();
    expect_outs("str_memadr", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    mem_ready = 1'b0;
    tick();
    expect_outs("str_memwr_wait", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00,
                1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    mem_ready = 1'b1;
    #1;
    expect_outs("str_memwr_done", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00,
                1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    expect_fetch("str_back_fetch", 1'b1);

    // B then Op=11.
    Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
    #1;
    check("b_regsrc", 32'(RegSrc), 32'd1);
    tick();
    expect_decode("b_decode");
    tick();
    expect_outs("b_branch", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00,
                1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    Op = 2'b11;
    #1;
    expect_fetch("ill_fetch", 1'b1);
    tick();
    expect_outs("ill_decode", 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    expect_fetch("ill_back_fetch", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
